dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  MEM-stage data-memory access controller between the pipeline and a variable-latency
//  data memory (valid/ready request, valid response). Converts load/store controls into bus
//  transactions, formats store data/strobes, extracts and extends load data.
//  Drives d_mem_busy into the stall unit, which freezes the whole pipeline while busy.
// PARAMETERS
//  TIMEOUT   256  cycles in REQ+WAIT before abort with bus_err; 0 disables the timeout
// PORTS
//  clk          in   1   clock; all state changes on rising edge
//  rst          in   1   synchronous reset, active-low (rst=0 resets on the clock edge)
//  mem_read     in   1   MEM-stage instruction is a load
//  mem_write    in   1   MEM-stage instruction is a store (never both with mem_read)
//  funct3       in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr         in   32  byte address from the ALU
//  wdata        in   32  rs2 store data
//  mem_advance  in   1   MEM/WB write enable (we_MEM): instruction leaves MEM this edge
//  d_mem_busy   out  1   stall request to the stall unit
//  rdata        out  32  formatted load result, valid while in DONE
//  misalign_err out  1   misaligned access flag (combinational)
//  bus_err      out  1   access aborted by timeout, valid while in DONE
//  req_valid    out  1   bus request valid
//  req_ready    in   1   bus accepts request
//  req_we       out  1   1 = write
//  req_addr     out  32  {addr[31:2],2'b00}
//  req_wstrb    out  4   byte strobes
//  req_wdata    out  32  lane-replicated store data
//  resp_valid   in   1   read data valid (reads only)
//  resp_rdata   in   32  raw read word
// BEHAVIOUR
//  Reset: state=IDLE, timer=0; req_valid, req_we, req_wstrb, req_wdata, req_addr, rdata,
//   bus_err = 0. Reset overrides everything, including a pending handshake;
//   resp_valid in IDLE is ignored.
//  access = (mem_read|mem_write) & ~misalign_err.
//  misalign_err = access-type & ((H/HU & addr[0]) | (W & |addr[1:0])). No bus request and
//   no busy for misaligned accesses. Reporting the trap is done elsewhere.
//  FSM:
//   IDLE: access -> latch addr/funct3/wdata/we into request regs -> REQ.
//   REQ:  req_valid=1, stable until req_ready. On req_valid&req_ready: store -> DONE,
//         load -> WAIT.
//   WAIT: req_valid=0. On resp_valid: rdata <= formatted resp_rdata, bus_err <= 0 -> DONE.
//   DONE: holds rdata/bus_err; mem_advance -> IDLE, else stay. This blocks a re-issue
//         while other stalls freeze MEM.
//  d_mem_busy = (IDLE & access) | REQ | WAIT. It is 0 in DONE.
//  Minimum latency:
//   - load, 1-cycle memory: busy 3 cycles (IDLE, REQ, WAIT).
//   - store, req_ready=1: busy 2 cycles.
//  Timer:
//   - clears on entering REQ and increments in REQ/WAIT.
//   - If TIMEOUT!=0 and the timer reaches TIMEOUT-1 without completing: go to DONE,
//     bus_err=1, rdata=0, req_valid drops.
//   - Completion in the same cycle as the timeout wins (no error).
//  Store format (off=addr[1:0]):
//   - SB: wstrb=4'b0001<<off, wdata={4{wdata[7:0]}}.
//   - SH: wstrb=4'b0011<<off, wdata={2{wdata[15:0]}}.
//   - SW: wstrb=4'hF.
//  Load format:
//   - byte/half selected by off.
//   - B/H sign-extend; BU/HU zero-extend.
//   - W passes through.
// TESTING
//  1 LW addr=0x100, req_ready=1, resp_valid 1 cycle after grant with 0xDEADBEEF ->
//    busy 3 cycles, rdata=0xDEADBEEF in DONE, exactly 1 request.
//  2 LB addr=0x103, resp 0x80112233 -> rdata=0xFFFFFF80; LBU -> 0x00000080;
//    LH 0x102 -> 0xFFFF8011.
//  3 SB addr=0x201, wdata=0x000000AB -> req_wstrb=4'b0010, req_wdata=0xABABABAB,
//    req_addr=0x200, no WAIT.
//  4 Load done, mem_advance held 0 for 5 cycles (i_mem stall) -> stays in DONE,
//    busy=0, no second req_valid.
//  5 TIMEOUT=8, req_ready=0 forever -> busy 9 cycles, then bus_err=1, rdata=0,
//    req_valid=0.
//  6 rst=0 during WAIT, resp_valid next cycle -> IDLE, outputs 0, response ignored.
//    LW addr=0x102 -> misalign_err=1, busy=0, no request.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller and the memory.
// The request channel uses a valid/ready handshake. The response channel is a
// single-cycle valid pulse that carries read data for loads only.
interface dmem_access_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [3:0]  req_wstrb;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;

   // The controller side issues requests and consumes responses.
   modport master (
      output req_valid,
      output req_we,
      output req_addr,
      output req_wstrb,
      output req_wdata,
      input  req_ready,
      input  resp_valid,
      input  resp_rdata
   );

   // The memory side accepts requests and returns read data.
   modport slave (
      input  req_valid,
      input  req_we,
      input  req_addr,
      input  req_wstrb,
      input  req_wdata,
      output req_ready,
      output resp_valid,
      output resp_rdata
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller.
// It turns load/store controls into bus transactions and formats store lanes and
// strobes. It also extracts and sign- or zero-extends load data. While an access
// is in flight it raises d_mem_busy so that the pipeline freezes.
module dmem_access_ctrl #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mem_read,
   input  logic                      mem_write,
   input  logic [2:0]                funct3,
   input  logic [31:0]               addr,
   input  logic [31:0]               wdata,
   input  logic                      mem_advance,
   output logic                      d_mem_busy,
   output logic [31:0]               rdata,
   output logic                      misalign_err,
   output logic                      bus_err,
   dmem_access_ctrl_if.master        bus
);

   // The timer can reach TIMEOUT: a load that is granted on the last budget
   // cycle still moves to WAIT before it is aborted there.
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic           req_we_q, req_we_d;
   logic [31:0]    req_addr_q, req_addr_d;
   logic [3:0]     req_wstrb_q, req_wstrb_d;
   logic [31:0]    req_wdata_q, req_wdata_d;
   logic [2:0]     funct3_q, funct3_d;
   logic [1:0]     off_q, off_d;
   logic [31:0]    rdata_q, rdata_d;
   logic           bus_err_q, bus_err_d;

   logic           is_half;
   logic           is_word;
   logic           access;
   logic           timeout_hit;
   logic [3:0]     st_wstrb;
   logic [31:0]    st_wdata;
   logic [7:0]     resp_byte [4];
   logic [7:0]     ld_byte;
   logic [15:0]    ld_half;
   logic [31:0]    ld_data;

   // Misalignment is decoded from the live MEM-stage controls. A misaligned
   // access never reaches the bus and never stalls; the trap is raised elsewhere.
   assign is_half      = (funct3[1:0] == 2'b01);
   assign is_word      = (funct3 == 3'b010);
   assign misalign_err = (mem_read | mem_write) &
                         ((is_half & addr[0]) | (is_word & (|addr[1:0])));
   assign access       = (mem_read | mem_write) & ~misalign_err;

   assign timeout_hit  = (TIMEOUT != 0) && (timer_q >= TIMER_LAST);

   // Per-lane views. Store lanes replicate the byte or halfword so that any
   // strobe position sees the right data. Response lanes feed the load extractor.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign resp_byte[gi] = bus.resp_rdata[8*gi +: 8];
      assign st_wdata[8*gi +: 8] =
         (funct3[1:0] == 2'b00) ? wdata[7:0] :
         (funct3[1:0] == 2'b01) ? wdata[8*(gi % 2) +: 8] :
                                  wdata[8*gi +: 8];
   end

   // Store byte strobes, shifted to the addressed lane.
   always_comb begin
      st_wstrb = 4'hF;
      case (funct3[1:0])
         2'b00:   st_wstrb = 4'b0001 << addr[1:0];
         2'b01:   st_wstrb = 4'b0011 << addr[1:0];
         default: st_wstrb = 4'hF;
      endcase
   end

   // Load extraction, using the width and offset that were latched at issue.
   always_comb begin
      ld_byte = resp_byte[off_q];
      ld_half = off_q[1] ? bus.resp_rdata[31:16] : bus.resp_rdata[15:0];
      ld_data = bus.resp_rdata;
      case (funct3_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'h000000, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'h0000, ld_half};
         default: ld_data = bus.resp_rdata;
      endcase
   end

   // Next-state and datapath updates for the access FSM.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      req_we_d    = req_we_q;
      req_addr_d  = req_addr_q;
      req_wstrb_d = req_wstrb_q;
      req_wdata_d = req_wdata_q;
      funct3_d    = funct3_q;
      off_d       = off_q;
      rdata_d     = rdata_q;
      bus_err_d   = bus_err_q;

      case (state_q)
         S_IDLE: begin
            if (access) begin
               req_we_d    = mem_write;
               req_addr_d  = {addr[31:2], 2'b00};
               req_wstrb_d = mem_write ? st_wstrb : 4'h0;
               req_wdata_d = mem_write ? st_wdata : 32'h0;
               funct3_d    = funct3;
               off_d       = addr[1:0];
               timer_d     = '0;
               state_d     = S_REQ;
            end
         end

         S_REQ: begin
            timer_d = timer_q + 1'b1;
            if (bus.req_ready && req_we_q) begin
               // A store is complete when it is accepted; this wins over a
               // timeout that expires in the same cycle.
               bus_err_d = 1'b0;
               state_d   = S_DONE;
            end else if (bus.req_ready) begin
               state_d = S_WAIT;
            end else if (timeout_hit) begin
               bus_err_d = 1'b1;
               rdata_d   = 32'h0;
               state_d   = S_DONE;
            end
         end

         S_WAIT: begin
            timer_d = timer_q + 1'b1;
            if (bus.resp_valid) begin
               rdata_d   = ld_data;
               bus_err_d = 1'b0;
               state_d   = S_DONE;
            end else if (timeout_hit) begin
               bus_err_d = 1'b1;
               rdata_d   = 32'h0;
               state_d   = S_DONE;
            end
         end

         S_DONE: begin
            // Stay here until the instruction leaves MEM. This prevents a
            // second issue while another stall source holds the pipeline.
            if (mem_advance) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         req_we_q    <= 1'b0;
         req_addr_q  <= 32'h0;
         req_wstrb_q <= 4'h0;
         req_wdata_q <= 32'h0;
         funct3_q    <= 3'b000;
         off_q       <= 2'b00;
         rdata_q     <= 32'h0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         req_we_q    <= req_we_d;
         req_addr_q  <= req_addr_d;
         req_wstrb_q <= req_wstrb_d;
         req_wdata_q <= req_wdata_d;
         funct3_q    <= funct3_d;
         off_q       <= off_d;
         rdata_q     <= rdata_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign bus.req_valid = (state_q == S_REQ);
   assign bus.req_we    = req_we_q;
   assign bus.req_addr  = req_addr_q;
   assign bus.req_wstrb = req_wstrb_q;
   assign bus.req_wdata = req_wdata_q;

   assign d_mem_busy = ((state_q == S_IDLE) & access) |
                       (state_q == S_REQ) | (state_q == S_WAIT);
   assign rdata      = rdata_q;
   assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl. It runs directed and randomized accesses
// against a reference model of the access rules: latency, timeout, store
// formatting and load extension.
module tb_dmem_access_ctrl;

   localparam int TMO = 8;

   logic        clk;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_advance;
   logic        d_mem_busy;
   logic [31:0] rdata;
   logic        misalign_err;
   logic        bus_err;

   int n_cmp;
   int n_bad;

   logic [2:0] ld_f3 [5];
   logic [2:0] st_f3 [3];

   dmem_access_ctrl_if bus ();

   dmem_access_ctrl #(.TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .funct3       (funct3),
      .addr         (addr),
      .wdata        (wdata),
      .mem_advance  (mem_advance),
      .d_mem_busy   (d_mem_busy),
      .rdata        (rdata),
      .misalign_err (misalign_err),
      .bus_err      (bus_err),
      .bus          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One memory access. Entry and exit happen just after a rising edge.
   // rdy_dly: REQ cycles before req_ready rises (large means never).
   // rsp_dly: WAIT cycles before resp_valid pulses. hold: DONE cycles held
   // without mem_advance.
   task automatic do_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int rdy_dly, input int rsp_dly,
                            input logic [31:0] rword, input int hold);
      int          off;
      int          n;
      int          exp_busy;
      int          exp_hs;
      int          busy_cnt;
      int          hs_cnt;
      logic        exp_mis;
      logic        timed_out;
      logic        done_seen;
      logic [31:0] b;
      logic [31:0] h;
      logic [31:0] exp_rdata;
      logic [31:0] exp_strb;
      logic [31:0] exp_wdata;

      // Reference expectations computed from the access rules.
      off       = int'(a % 4);
      exp_mis   = (rd || wr) &&
                  (((f3 == 3'b001 || f3 == 3'b101) && (a % 2 != 0)) ||
                   (f3 == 3'b010 && off != 0));
      n         = wr ? rdy_dly + 1 : rdy_dly + rsp_dly + 2;
      timed_out = !exp_mis && (n > TMO);
      exp_busy  = exp_mis ? 0 : (timed_out ? TMO + 1 : n + 1);
      exp_hs    = (exp_mis || rdy_dly >= TMO) ? 0 : 1;

      b = (rword >> (8 * off)) & 32'hFF;
      h = (rword >> (8 * (off & 2))) & 32'hFFFF;
      case (f3)
         3'b000:  exp_rdata = (b >= 128) ? b + 32'hFFFFFF00 : b;
         3'b100:  exp_rdata = b;
         3'b001:  exp_rdata = (h >= 32768) ? h + 32'hFFFF0000 : h;
         3'b101:  exp_rdata = h;
         default: exp_rdata = rword;
      endcase
      if (timed_out) exp_rdata = 32'h0;

      case (f3[1:0])
         2'b00:   begin exp_strb = 32'd1 << off;  exp_wdata = (wd & 32'hFF) * 32'h01010101;   end
         2'b01:   begin exp_strb = 32'd3 << off;  exp_wdata = (wd & 32'hFFFF) * 32'h00010001; end
         default: begin exp_strb = 32'd15;        exp_wdata = wd;                               end
      endcase

      mem_read    = rd;
      mem_write   = wr;
      funct3      = f3;
      addr        = a;
      wdata       = wd;
      mem_advance = 1'b0;
      busy_cnt    = 0;
      hs_cnt      = 0;
      done_seen   = 1'b0;

      for (int c = 0; c < 64; c++) begin
         bus.req_ready  = (c >= rdy_dly + 1);
         bus.resp_valid = rd && (c == rdy_dly + rsp_dly + 2);
         bus.resp_rdata = bus.resp_valid ? rword : $urandom();
         @(negedge clk);
         if (c == 0) check({tag, "/misalign"}, 32'(misalign_err), 32'(exp_mis));
         if (!d_mem_busy) begin
            done_seen = 1'b1;
            break;
         end
         busy_cnt++;
         if (bus.req_valid && bus.req_ready) begin
            hs_cnt++;
            check({tag, "/req_addr"}, bus.req_addr, a & 32'hFFFFFFFC);
            check({tag, "/req_we"}, 32'(bus.req_we), 32'(wr));
            if (wr) begin
               check({tag, "/req_wstrb"}, 32'(bus.req_wstrb), exp_strb);
               check({tag, "/req_wdata"}, bus.req_wdata, exp_wdata);
            end
         end
         @(posedge clk);
         #1;
      end

      check({tag, "/finished"}, 32'(done_seen), 32'd1);
      check({tag, "/busy_cycles"}, busy_cnt, exp_busy);
      check({tag, "/requests"}, hs_cnt, exp_hs);
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      check({tag, "/req_valid_end"}, 32'(bus.req_valid), 32'd0);

      if (!exp_mis) begin
         check({tag, "/bus_err"}, 32'(bus_err), 32'(timed_out));
         if (rd || timed_out) check({tag, "/rdata"}, rdata, exp_rdata);
         for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check({tag, "/hold_busy"}, 32'(d_mem_busy), 32'd0);
            check({tag, "/hold_req_valid"}, 32'(bus.req_valid), 32'd0);
            if (rd || timed_out) check({tag, "/hold_rdata"}, rdata, exp_rdata);
         end
         mem_advance = 1'b1;
      end

      @(posedge clk);
      #1;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_advance = 1'b0;
      @(negedge clk);
      check({tag, "/idle_req_valid"}, 32'(bus.req_valid), 32'd0);
      check({tag, "/idle_busy"}, 32'(d_mem_busy), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010;
      ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
      st_f3[0] = 3'b000; st_f3[1] = 3'b001; st_f3[2] = 3'b010;

      rst            = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      funct3         = 3'b000;
      addr           = 32'h0;
      wdata          = 32'h0;
      mem_advance    = 1'b0;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_rdata = 32'h0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset/busy", 32'(d_mem_busy), 32'd0);
      check("reset/req_valid", 32'(bus.req_valid), 32'd0);
      check("reset/req_we", 32'(bus.req_we), 32'd0);
      check("reset/req_addr", bus.req_addr, 32'h0);
      check("reset/req_wstrb", 32'(bus.req_wstrb), 32'h0);
      check("reset/req_wdata", bus.req_wdata, 32'h0);
      check("reset/rdata", rdata, 32'h0);
      check("reset/bus_err", 32'(bus_err), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Word load with a one-cycle memory.
      do_access("lw_basic", 1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0);
      // Sub-word loads with sign and zero extension.
      do_access("lb_103", 1, 0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80112233, 0);
      do_access("lbu_103", 1, 0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80112233, 0);
      do_access("lh_102", 1, 0, 3'b001, 32'h102, 32'h0, 0, 0, 32'h80112233, 0);
      do_access("lhu_100", 1, 0, 3'b101, 32'h100, 32'h0, 1, 2, 32'h1234F00D, 0);
      // Byte store to lane 1.
      do_access("sb_201", 0, 1, 3'b000, 32'h201, 32'h000000AB, 0, 0, 32'h0, 0);
      do_access("sh_202", 0, 1, 3'b001, 32'h202, 32'h5555CAFE, 2, 0, 32'h0, 1);
      // DONE held by an external stall: no re-issue, no busy.
      do_access("lw_hold", 1, 0, 3'b010, 32'h104, 32'h0, 0, 1, 32'h0BADF00D, 5);
      // Timeouts: no grant, and a granted load with a late response.
      do_access("lw_tmo", 1, 0, 3'b010, 32'h400, 32'h0, 1000, 0, 32'h11111111, 0);
      do_access("sw_after_tmo", 0, 1, 3'b010, 32'h404, 32'h76543210, 0, 0, 32'h0, 0);
      do_access("sw_tmo", 0, 1, 3'b010, 32'h408, 32'h1, 1000, 0, 32'h0, 1);
      do_access("lw_resp_tmo", 1, 0, 3'b010, 32'h40C, 32'h0, 0, 10, 32'h22222222, 0);
      // Completion in the last budget cycle wins over the timeout.
      do_access("sw_edge", 0, 1, 3'b010, 32'h410, 32'hA5A5A5A5, 7, 0, 32'h0, 0);
      do_access("lw_edge", 1, 0, 3'b010, 32'h414, 32'h0, 6, 0, 32'h33333333, 0);
      // Misaligned word load: no request, no busy.
      do_access("lw_misalign", 1, 0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0, 0);
      do_access("sh_misalign", 0, 1, 3'b001, 32'h203, 32'hFFFF, 0, 0, 32'h0, 0);

      // Reset during WAIT with a response arriving right after it.
      mem_read      = 1'b1;
      funct3        = 3'b010;
      addr          = 32'h300;
      bus.req_ready = 1'b1;
      @(negedge clk);
      check("rst_wait/idle_busy", 32'(d_mem_busy), 32'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_wait/req_valid", 32'(bus.req_valid), 32'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_wait/wait_busy", 32'(d_mem_busy), 32'd1);
      check("rst_wait/wait_req_valid", 32'(bus.req_valid), 32'd0);
      rst           = 1'b0;
      bus.req_ready = 1'b0;
      @(posedge clk);
      #1;
      rst            = 1'b1;
      mem_read       = 1'b0;
      bus.resp_valid = 1'b1;
      bus.resp_rdata = 32'h12345678;
      @(negedge clk);
      check("rst_wait/busy", 32'(d_mem_busy), 32'd0);
      check("rst_wait/req_valid_after", 32'(bus.req_valid), 32'd0);
      check("rst_wait/req_addr", bus.req_addr, 32'h0);
      check("rst_wait/req_we", 32'(bus.req_we), 32'd0);
      check("rst_wait/rdata", rdata, 32'h0);
      check("rst_wait/bus_err", 32'(bus_err), 32'd0);
      @(posedge clk);
      #1;
      bus.resp_valid = 1'b0;
      @(negedge clk);
      check("rst_wait/resp_ignored", rdata, 32'h0);
      check("rst_wait/busy2", 32'(d_mem_busy), 32'd0);
      @(posedge clk);
      #1;

      // Randomized accesses, mostly aligned, all within the timeout budget.
      for (int i = 0; i < 24; i++) begin
         logic        rd;
         logic [2:0]  f3;
         logic [31:0] a;
         int          sz;
         rd = 1'($urandom_range(0, 1));
         f3 = rd ? ld_f3[$urandom_range(0, 4)] : st_f3[$urandom_range(0, 2)];
         sz = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
         a  = $urandom();
         if ($urandom_range(0, 5) != 0) a = a & ~(32'(sz) - 32'd1);
         do_access($sformatf("rnd%0d", i), rd, !rd, f3, a, $urandom(),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                   $urandom(), int'($urandom_range(0, 2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
